safety_island_dma_sched: RTL and testbench

- Round-robin scheduler sharing the safety-island DMA backend request port among NumChan requesters (cores, debug, external mailbox).
- Accepts one 1D transfer descriptor per channel handshake and stages it into a registered backend request slot.
- Tracks issue order in an in-order tracking FIFO and routes each backend completion back to the originating channel as done/error pulses.
- Sits between the per-requester register frontends and the single DMA backend request/response interface.

---
 rtl/safety_island_dma_sched_pkg.sv | 9 +
 rtl/safety_island_dma_sched_if.sv | 24 ++
 rtl/safety_island_dma_rr_arb.sv | 48 ++++
 rtl/safety_island_dma_sched.sv | 156 +++++++++++++++
 tb/tb_safety_island_dma_sched.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/safety_island_dma_sched_pkg.sv
// Shared helpers for the safety-island DMA request scheduler.
package safety_island_dma_sched_pkg;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/safety_island_dma_sched_if.sv
// Backend request/response port of the DMA scheduler.
interface safety_island_dma_sched_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned LenWidth  = 24
) ();
  logic                 be_valid;
  logic                 be_ready;
  logic [AddrWidth-1:0] be_src;
  logic [AddrWidth-1:0] be_dst;
  logic [LenWidth-1:0]  be_len;
  logic                 be_rsp_valid;
  logic                 be_rsp_error;
  logic                 be_rsp_ready;

  modport master (
    output be_valid, be_src, be_dst, be_len, be_rsp_ready,
    input  be_ready, be_rsp_valid, be_rsp_error
  );

  modport slave (
    input  be_valid, be_src, be_dst, be_len, be_rsp_ready,
    output be_ready, be_rsp_valid, be_rsp_error
  );
endinterface

// File: rtl/safety_island_dma_rr_arb.sv
// Round-robin grant search over the requesting channels; pointer moves past each winner.
module safety_island_dma_rr_arb
  import safety_island_dma_sched_pkg::*;
#(
  parameter int unsigned NumChan = 4,
  parameter int unsigned IdxW    = clog2_min1(NumChan)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumChan-1:0] req_i,
  input  logic               en_i,
  output logic [NumChan-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               valid_o
);
  localparam int unsigned SumW = IdxW + 1;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [SumW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < NumChan; k++) begin
      cand = {1'b0, ptr_q} + SumW'(k);
      if (cand >= SumW'(NumChan)) cand = cand - SumW'(NumChan);
      if (en_i && !valid_o && req_i[cand[IdxW-1:0]]) begin
        valid_o                 = 1'b1;
        gnt_o[cand[IdxW-1:0]]   = 1'b1;
        idx_o                   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (valid_o) begin
      ptr_d = (idx_o == IdxW'(NumChan - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/safety_island_dma_sched.sv
// Shares the DMA backend request port among NumChan requesters and routes
// in-order completions back to the originating channel.
module safety_island_dma_sched
  import safety_island_dma_sched_pkg::*;
#(
  parameter int unsigned NumChan        = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned LenWidth       = 24,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumChan-1:0]             chan_valid_i,
  output logic [NumChan-1:0]             chan_ready_o,
  input  logic [NumChan*AddrWidth-1:0]   chan_src_i,
  input  logic [NumChan*AddrWidth-1:0]   chan_dst_i,
  input  logic [NumChan*LenWidth-1:0]    chan_len_i,
  output logic [NumChan-1:0]             chan_done_o,
  output logic [NumChan-1:0]             chan_err_o,
  output logic [NumChan-1:0]             chan_busy_o,
  safety_island_dma_sched_if.master      be
);
  localparam int unsigned IdxW = clog2_min1(NumChan);
  localparam int unsigned PtrW = clog2_min1(MaxOutstanding);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef struct packed {
    logic [AddrWidth-1:0] src;
    logic [AddrWidth-1:0] dst;
    logic [LenWidth-1:0]  len;
  } sched_desc_t;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(MaxOutstanding - 1)) ? '0 : ptr + 1'b1;
  endfunction

  sched_desc_t       desc_q, sel_desc;
  logic              be_valid_q;
  logic              load_en, push, pop, fifo_full, fifo_empty;
  logic [NumChan-1:0] gnt, dec_vec, done_q, err_q, cnt_bad;
  logic [IdxW-1:0]   gnt_idx, head_idx;
  logic [IdxW-1:0]   fifo_mem_q [MaxOutstanding];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   occ_q;
  logic [CntW-1:0]   cnt_q [NumChan];
  logic [CntW-1:0]   cnt_d [NumChan];

  // Full uses the pre-pop occupancy so a completion never frees a slot combinationally.
  assign fifo_full  = (occ_q == CntW'(MaxOutstanding));
  assign fifo_empty = (occ_q == '0);
  assign load_en    = (!be_valid_q || be.be_ready) && !fifo_full;
  assign pop        = be.be_rsp_valid && !fifo_empty;
  assign head_idx   = fifo_mem_q[rd_ptr_q];

  safety_island_dma_rr_arb #(
    .NumChan (NumChan),
    .IdxW    (IdxW)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (chan_valid_i),
    .en_i    (load_en),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (push)
  );

  always_comb begin
    sel_desc = '0;
    for (int c = 0; c < NumChan; c++) begin
      if (gnt[c]) begin
        sel_desc.src = chan_src_i[c*AddrWidth +: AddrWidth];
        sel_desc.dst = chan_dst_i[c*AddrWidth +: AddrWidth];
        sel_desc.len = chan_len_i[c*LenWidth +: LenWidth];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      be_valid_q <= 1'b0;
      desc_q     <= '0;
    end else if (push) begin
      be_valid_q <= 1'b1;
      desc_q     <= sel_desc;
    end else if (be.be_ready) begin
      be_valid_q <= 1'b0;
    end
  end

  // In-order tracking FIFO of issuing channel indices.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      occ_q <= occ_q + 1'b1;
      else if (pop && !push) occ_q <= occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= gnt_idx;
  end

  always_comb begin
    dec_vec = '0;
    cnt_bad = '0;
    for (int i = 0; i < NumChan; i++) begin
      dec_vec[i] = pop && (head_idx == IdxW'(i));
      cnt_d[i]   = cnt_q[i];
      if (gnt[i] && !dec_vec[i])      cnt_d[i] = cnt_q[i] + 1'b1;
      else if (dec_vec[i] && !gnt[i]) cnt_d[i] = cnt_q[i] - 1'b1;
      cnt_bad[i] = (gnt[i] && !dec_vec[i] && (cnt_q[i] == CntW'(MaxOutstanding))) ||
                   (dec_vec[i] && !gnt[i] && (cnt_q[i] == '0));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q <= '0;
      err_q  <= '0;
      for (int i = 0; i < NumChan; i++) cnt_q[i] <= '0;
    end else begin
      done_q <= dec_vec;
      err_q  <= dec_vec & {NumChan{be.be_rsp_error}};
      for (int i = 0; i < NumChan; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    chan_busy_o = '0;
    for (int i = 0; i < NumChan; i++) chan_busy_o[i] = (cnt_q[i] != '0);
  end

  assign chan_ready_o    = gnt;
  assign chan_done_o     = done_q;
  assign chan_err_o      = err_q;
  assign be.be_valid     = be_valid_q;
  assign be.be_src       = desc_q.src;
  assign be.be_dst       = desc_q.dst;
  assign be.be_len       = desc_q.len;
  assign be.be_rsp_ready = !fifo_empty;

  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(chan_ready_o));
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (be_valid_q && !be.be_ready) |=> (be_valid_q && $stable(desc_q)));
  a_rsp_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(be.be_rsp_valid && fifo_empty));
  a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_bad == '0);
endmodule

// File: tb/tb_safety_island_dma_sched.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_safety_island_dma_sched;
  localparam int unsigned NumChan = 4;
  localparam int unsigned AW      = 32;
  localparam int unsigned LW      = 24;
  localparam int unsigned MaxOut  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NumChan-1:0]    chan_valid, chan_ready, chan_done, chan_err, chan_busy;
  logic [NumChan*AW-1:0] chan_src, chan_dst;
  logic [NumChan*LW-1:0] chan_len;

  safety_island_dma_sched_if #(.AddrWidth(AW), .LenWidth(LW)) be_if ();

  safety_island_dma_sched #(
    .NumChan        (NumChan),
    .AddrWidth      (AW),
    .LenWidth       (LW),
    .MaxOutstanding (MaxOut)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .chan_valid_i (chan_valid),
    .chan_ready_o (chan_ready),
    .chan_src_i   (chan_src),
    .chan_dst_i   (chan_dst),
    .chan_len_i   (chan_len),
    .chan_done_o  (chan_done),
    .chan_err_o   (chan_err),
    .chan_busy_o  (chan_busy),
    .be           (be_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    chan_valid          = '0;
    chan_src            = '0;
    chan_dst            = '0;
    chan_len            = '0;
    be_if.be_ready      = 1'b0;
    be_if.be_rsp_valid  = 1'b0;
    be_if.be_rsp_error  = 1'b0;
  endtask

  task automatic set_chan(input int c, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] l);
    chan_src[c*AW +: AW] = s;
    chan_dst[c*AW +: AW] = d;
    chan_len[c*LW +: LW] = l;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    chan_valid     = '1;
    be_if.be_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (be_if.be_valid !== 1'b0) begin n_err++; $display("FAIL reset_be_valid: got %b want 0", be_if.be_valid); end
    n_cmp++; if ({be_if.be_src, be_if.be_dst, be_if.be_len} !== '0) begin n_err++; $display("FAIL reset_be_fields: got %h want 0", {be_if.be_src, be_if.be_dst, be_if.be_len}); end
    n_cmp++; if ({chan_done, chan_err, chan_busy} !== '0) begin n_err++; $display("FAIL reset_chan_outs: got %b want 0", {chan_done, chan_err, chan_busy}); end
    n_cmp++; if (be_if.be_rsp_ready !== 1'b0) begin n_err++; $display("FAIL reset_rsp_ready: got %b want 0", be_if.be_rsp_ready); end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    be_if.be_ready = 1'b1;
    chan_valid     = 4'b0010;
    set_chan(1, 32'h1000, 32'h2000, 24'd64);
    #1;
    n_cmp++; if (chan_ready !== 4'b0010) begin n_err++; $display("FAIL single_ready: got %b want 0010", chan_ready); end
    tick();
    chan_valid = '0;
    n_cmp++; if (be_if.be_valid !== 1'b1) begin n_err++; $display("FAIL single_be_valid: got %b want 1", be_if.be_valid); end
    n_cmp++; if ({be_if.be_src, be_if.be_dst, be_if.be_len} !== {32'h1000, 32'h2000, 24'd64}) begin n_err++; $display("FAIL single_fields: got %h %h %h want 1000 2000 40", be_if.be_src, be_if.be_dst, be_if.be_len); end
    n_cmp++; if (chan_busy !== 4'b0010) begin n_err++; $display("FAIL single_busy: got %b want 0010", chan_busy); end
    tick();
    n_cmp++; if (be_if.be_valid !== 1'b0) begin n_err++; $display("FAIL single_be_drop: got %b want 0", be_if.be_valid); end
    tick();
    tick();
    tick();
    be_if.be_rsp_valid = 1'b1;
    tick();
    be_if.be_rsp_valid = 1'b0;
    n_cmp++; if (chan_done !== 4'b0010 || chan_err !== 4'b0000) begin n_err++; $display("FAIL single_done: got done %b err %b want 0010 0000", chan_done, chan_err); end
    n_cmp++; if (chan_busy !== 4'b0000) begin n_err++; $display("FAIL single_busy_clear: got %b want 0000", chan_busy); end
    tick();
    n_cmp++; if (chan_done !== 4'b0000) begin n_err++; $display("FAIL single_done_pulse: got %b want 0000", chan_done); end
  endtask

  task automatic test_round_robin();
    int nxt = 0;
    int grants = 0;
    logic d1 = 1'b0, d2 = 1'b0, acc;
    logic [NumChan-1:0] want;
    do_reset();
    be_if.be_ready = 1'b1;
    for (int c = 0; c < NumChan; c++) set_chan(c, $urandom, $urandom, LW'($urandom));
    for (int cyc = 0; cyc < 24; cyc++) begin
      chan_valid = (cyc < 16) ? 4'b1111 : 4'b0000;
      acc = be_if.be_valid;
      be_if.be_rsp_valid = d2;
      #1;
      if (chan_ready != '0) begin
        want = '0;
        want[nxt] = 1'b1;
        n_cmp++; if (chan_ready !== want) begin n_err++; $display("FAIL rr_order: got %b want %b", chan_ready, want); end
        nxt = (nxt + 1) % NumChan;
        grants++;
      end
      tick();
      d2 = d1;
      d1 = acc;
    end
    be_if.be_rsp_valid = 1'b0;
    n_cmp++; if (grants !== 16) begin n_err++; $display("FAIL rr_throughput: got %0d grants want 16", grants); end
    n_cmp++; if (chan_busy !== 4'b0000) begin n_err++; $display("FAIL rr_drain_busy: got %b want 0000", chan_busy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    chan_valid = 4'b0101;
    set_chan(0, 32'hA000_0000, 32'hA100_0000, 24'h000111);
    set_chan(2, 32'hC000_0000, 32'hC100_0000, 24'h000333);
    #1;
    n_cmp++; if (chan_ready !== 4'b0001) begin n_err++; $display("FAIL bp_first_grant: got %b want 0001", chan_ready); end
    tick();
    chan_valid = 4'b0100;
    set_chan(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 24'hBEEF00);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (chan_ready !== 4'b0000) begin n_err++; $display("FAIL bp_no_grant: got %b want 0000", chan_ready); end
      n_cmp++; if (be_if.be_valid !== 1'b1 || be_if.be_src !== 32'hA000_0000 || be_if.be_len !== 24'h000111) begin n_err++; $display("FAIL bp_stable: got %b %h %h want 1 a0000000 000111", be_if.be_valid, be_if.be_src, be_if.be_len); end
      tick();
    end
    be_if.be_ready = 1'b1;
    #1;
    n_cmp++; if (chan_ready !== 4'b0100) begin n_err++; $display("FAIL bp_release_grant: got %b want 0100", chan_ready); end
    tick();
    chan_valid = '0;
    n_cmp++; if (be_if.be_valid !== 1'b1 || be_if.be_src !== 32'hC000_0000) begin n_err++; $display("FAIL bp_second_staged: got %b %h want 1 c0000000", be_if.be_valid, be_if.be_src); end
    be_if.be_rsp_valid = 1'b1;
    tick();
    n_cmp++; if (chan_done !== 4'b0001) begin n_err++; $display("FAIL bp_done0: got %b want 0001", chan_done); end
    tick();
    be_if.be_rsp_valid = 1'b0;
    n_cmp++; if (chan_done !== 4'b0100) begin n_err++; $display("FAIL bp_done2: got %b want 0100", chan_done); end
    tick();
    n_cmp++; if (chan_busy !== 4'b0000) begin n_err++; $display("FAIL bp_busy: got %b want 0000", chan_busy); end
  endtask

  task automatic test_full();
    logic [NumChan-1:0] want;
    do_reset();
    be_if.be_ready = 1'b1;
    chan_valid     = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      want = '0;
      want[k] = 1'b1;
      #1;
      n_cmp++; if (chan_ready !== want) begin n_err++; $display("FAIL full_fill: got %b want %b", chan_ready, want); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (chan_ready !== 4'b0000) begin n_err++; $display("FAIL full_block: got %b want 0000", chan_ready); end
      tick();
    end
    be_if.be_rsp_valid = 1'b1;
    #1;
    n_cmp++; if (chan_ready !== 4'b0000) begin n_err++; $display("FAIL full_same_cycle_pop: got %b want 0000", chan_ready); end
    tick();
    be_if.be_rsp_valid = 1'b0;
    n_cmp++; if (chan_done !== 4'b0001) begin n_err++; $display("FAIL full_pop_done: got %b want 0001", chan_done); end
    n_cmp++; if (chan_ready !== 4'b0001) begin n_err++; $display("FAIL full_regrant: got %b want 0001", chan_ready); end
    tick();
    chan_valid = '0;
    be_if.be_rsp_valid = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    be_if.be_rsp_valid = 1'b0;
    tick();
    n_cmp++; if (chan_busy !== 4'b0000 || be_if.be_rsp_ready !== 1'b0) begin n_err++; $display("FAIL full_drain: got busy %b rsp_ready %b want 0000 0", chan_busy, be_if.be_rsp_ready); end
  endtask

  task automatic test_error();
    do_reset();
    be_if.be_ready = 1'b1;
    chan_valid     = 4'b1000;
    set_chan(3, 32'h3000, 32'h3100, 24'd16);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (chan_ready !== 4'b1000) begin n_err++; $display("FAIL err_issue: got %b want 1000", chan_ready); end
      tick();
    end
    be_if.be_rsp_valid = 1'b1;
    be_if.be_rsp_error = 1'b1;
    #1;
    n_cmp++; if (chan_ready !== 4'b1000) begin n_err++; $display("FAIL err_grant_c: got %b want 1000", chan_ready); end
    tick();
    chan_valid = '0;
    be_if.be_rsp_valid = 1'b0;
    be_if.be_rsp_error = 1'b0;
    n_cmp++; if (chan_done !== 4'b1000 || chan_err !== 4'b1000) begin n_err++; $display("FAIL err_a_done: got done %b err %b want 1000 1000", chan_done, chan_err); end
    n_cmp++; if (chan_busy !== 4'b1000) begin n_err++; $display("FAIL err_a_busy: got %b want 1000", chan_busy); end
    tick();
    be_if.be_rsp_valid = 1'b1;
    tick();
    n_cmp++; if (chan_done !== 4'b1000 || chan_err !== 4'b0000) begin n_err++; $display("FAIL err_b_done: got done %b err %b want 1000 0000", chan_done, chan_err); end
    n_cmp++; if (chan_busy !== 4'b1000) begin n_err++; $display("FAIL err_b_busy: got %b want 1000", chan_busy); end
    tick();
    be_if.be_rsp_valid = 1'b0;
    n_cmp++; if (chan_done !== 4'b1000 || chan_busy !== 4'b0000) begin n_err++; $display("FAIL err_c_done: got done %b busy %b want 1000 0000", chan_done, chan_busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    be_if.be_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chan_valid = '0;
      chan_valid[c] = 1'b1;
      set_chan(c, 32'h5000 + c, 32'h6000 + c, 24'd8);
      tick();
    end
    chan_valid     = '0;
    be_if.be_ready = 1'b0;
    n_cmp++; if (be_if.be_valid !== 1'b1 || chan_busy !== 4'b0111) begin n_err++; $display("FAIL rstmid_pre: got valid %b busy %b want 1 0111", be_if.be_valid, chan_busy); end
    rst = 1'b1;
    tick();
    n_cmp++; if ({be_if.be_valid, be_if.be_src, be_if.be_dst, be_if.be_len} !== '0) begin n_err++; $display("FAIL rstmid_be: got %h want 0", {be_if.be_valid, be_if.be_src, be_if.be_dst, be_if.be_len}); end
    n_cmp++; if ({chan_done, chan_err, chan_busy, be_if.be_rsp_ready} !== '0) begin n_err++; $display("FAIL rstmid_chan: got %b want 0", {chan_done, chan_err, chan_busy, be_if.be_rsp_ready}); end
    rst = 1'b0;
    chan_valid     = 4'b1111;
    be_if.be_ready = 1'b1;
    #1;
    n_cmp++; if (chan_ready !== 4'b0001) begin n_err++; $display("FAIL rstmid_rr_ptr: got %b want 0001", chan_ready); end
    tick();
    do_reset();
  endtask

  task automatic test_random();
    logic               m_valid = 1'b0;
    logic [AW-1:0]      m_src = '0, m_dst = '0;
    logic [LW-1:0]      m_len = '0;
    logic [NumChan-1:0] m_done = '0, m_err = '0, m_busy, want;
    int                 q[$];
    int                 cnt[NumChan];
    int                 rr = 0, acc_cnt = 0, g, c, h;
    logic               load;
    do_reset();
    for (int i = 0; i < NumChan; i++) cnt[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      m_busy = '0;
      for (int i = 0; i < NumChan; i++) m_busy[i] = (cnt[i] != 0);
      n_cmp++; if (be_if.be_valid !== m_valid) begin n_err++; $display("FAIL rnd_be_valid @%0d: got %b want %b", cyc, be_if.be_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if ({be_if.be_src, be_if.be_dst, be_if.be_len} !== {m_src, m_dst, m_len}) begin n_err++; $display("FAIL rnd_be_fields @%0d: got %h want %h", cyc, {be_if.be_src, be_if.be_dst, be_if.be_len}, {m_src, m_dst, m_len}); end
      end
      n_cmp++; if (chan_done !== m_done || (chan_err & chan_done) !== m_err) begin n_err++; $display("FAIL rnd_done @%0d: got %b/%b want %b/%b", cyc, chan_done, chan_err & chan_done, m_done, m_err); end
      n_cmp++; if (chan_busy !== m_busy) begin n_err++; $display("FAIL rnd_busy @%0d: got %b want %b", cyc, chan_busy, m_busy); end

      chan_valid = NumChan'($urandom);
      for (int i = 0; i < NumChan; i++) set_chan(i, $urandom, $urandom, LW'($urandom));
      be_if.be_ready     = ($urandom_range(0, 3) != 0);
      be_if.be_rsp_valid = (acc_cnt > 0) && ($urandom_range(0, 1) == 1);
      be_if.be_rsp_error = 1'($urandom);
      #1;

      load = (!m_valid || be_if.be_ready) && (q.size() < MaxOut);
      g = -1;
      if (load) begin
        for (int k = 0; k < NumChan; k++) begin
          c = (rr + k) % NumChan;
          if (g < 0 && chan_valid[c]) g = c;
        end
      end
      want = '0;
      if (g >= 0) want[g] = 1'b1;
      n_cmp++; if (chan_ready !== want) begin n_err++; $display("FAIL rnd_grant @%0d: got %b want %b", cyc, chan_ready, want); end
      n_cmp++; if (be_if.be_rsp_ready !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_rsp_ready @%0d: got %b want %b", cyc, be_if.be_rsp_ready, q.size() != 0); end

      m_done = '0;
      m_err  = '0;
      if (be_if.be_rsp_valid && q.size() > 0) begin
        h = q.pop_front();
        m_done[h] = 1'b1;
        m_err[h]  = be_if.be_rsp_error;
        cnt[h]--;
        acc_cnt--;
      end
      if (m_valid && be_if.be_ready) acc_cnt++;
      if (g >= 0) begin
        q.push_back(g);
        m_valid = 1'b1;
        m_src   = chan_src[g*AW +: AW];
        m_dst   = chan_dst[g*AW +: AW];
        m_len   = chan_len[g*LW +: LW];
        rr      = (g + 1) % NumChan;
        cnt[g]++;
      end else if (be_if.be_ready) begin
        m_valid = 1'b0;
      end
      tick();
    end
    do_reset();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full();
    test_error();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
